// File: rtl/sockit_spi_csr_if.sv
// Register bus plus command/response streams of the sockit SPI CSR block.
interface sockit_spi_csr_if;
  logic        reg_wen;
  logic        reg_ren;
  logic [2:0]  reg_adr;
  logic [31:0] reg_wdt;
  logic [31:0] reg_rdt;
  logic        reg_irq;
  logic        cmo_vld;
  logic        cmo_rdy;
  logic [11:0] cmo_ctl;
  logic [31:0] cmo_dat;
  logic        cmi_vld;
  logic        cmi_rdy;
  logic [31:0] cmi_dat;

  // CPU bus master and SPI sequencer side
  modport master (
    output reg_wen, reg_ren, reg_adr, reg_wdt, cmo_rdy, cmi_vld, cmi_dat,
    input  reg_rdt, reg_irq, cmo_vld, cmo_ctl, cmo_dat, cmi_rdy
  );

  // CSR block side
  modport slave (
    input  reg_wen, reg_ren, reg_adr, reg_wdt, cmo_rdy, cmi_vld, cmi_dat,
    output reg_rdt, reg_irq, cmo_vld, cmo_ctl, cmo_dat, cmi_rdy
  );
endinterface

// File: rtl/sockit_spi_csr.sv
// CSR block for the sockit SPI master: configuration, offsets, interrupts,
// and the command/response FIFOs between the CPU and the SPI sequencer.
module sockit_spi_csr #(
  parameter logic [31:0] CFG_RST   = 32'h00000000,
  parameter logic [31:0] CFG_MSK   = 32'hffffffff,
  parameter logic [31:0] ADR_ROF   = 32'h00000000,
  parameter logic [31:0] ADR_WOF   = 32'h00000000,
  parameter int          SSN       = 8,
  parameter int          CMD_DEPTH = 4,
  parameter int          RSP_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  sockit_spi_csr_if.slave     bus,
  output logic [31:0]         spi_cfg,
  output logic [SSN-1:0]      spi_sss,
  output logic [31:0]         adr_rof,
  output logic [31:0]         adr_wof
);

  localparam int CAW = $clog2(CMD_DEPTH);
  localparam int RAW = $clog2(RSP_DEPTH);

  logic [11:0]  cmd_ctl_mem [CMD_DEPTH];
  logic [31:0]  cmd_dat_mem [CMD_DEPTH];
  logic [CAW-1:0] cmd_wpt, cmd_rpt;
  logic [CAW:0]   cmd_cnt;
  logic [31:0]  rsp_mem [RSP_DEPTH];
  logic [RAW-1:0] rsp_wpt, rsp_rpt;
  logic [RAW:0]   rsp_cnt;
  logic [31:0]  dat_stg;
  logic [3:0]   irq_sts, irq_ena, irq_set, irq_clr;
  logic         cmd_full, cmd_empty, rsp_full, rsp_empty;
  logic         cmd_push_req, cmd_push, cmd_pop, cmd_ovf, cmd_done;
  logic         rsp_pop_req, rsp_push, rsp_pop, rsp_udf;
  logic [31:0]  par_val, sts_val;

  // FIFO flags, stream handshakes and interrupt events
  always_comb begin
    cmd_full     = (cmd_cnt == (CAW+1)'(CMD_DEPTH));
    cmd_empty    = (cmd_cnt == '0);
    rsp_full     = (rsp_cnt == (RAW+1)'(RSP_DEPTH));
    rsp_empty    = (rsp_cnt == '0);
    cmd_push_req = bus.reg_wen & (bus.reg_adr == 3'd2);
    cmd_push     = cmd_push_req & ~cmd_full;
    cmd_ovf      = cmd_push_req & cmd_full;
    cmd_pop      = ~cmd_empty & bus.cmo_rdy;
    // the queue only drains to empty if nothing is pushed in the same cycle
    cmd_done     = cmd_pop & ~cmd_push & (cmd_cnt == (CAW+1)'(1));
    rsp_push     = bus.cmi_vld & ~rsp_full;
    rsp_pop_req  = bus.reg_ren & (bus.reg_adr == 3'd3);
    rsp_pop      = rsp_pop_req & ~rsp_empty;
    rsp_udf      = rsp_pop_req & rsp_empty;
    irq_set      = {rsp_udf, cmd_ovf, rsp_push, cmd_done};
    irq_clr      = (bus.reg_wen && bus.reg_adr == 3'd4) ? bus.reg_wdt[3:0] : 4'b0000;
    par_val      = {8'(CAW), 8'(RAW), 12'b0, 4'(SSN)};
    sts_val      = {8'(cmd_cnt), 8'(rsp_cnt), 13'b0, cmd_full, cmd_empty, rsp_empty};
  end

  assign bus.cmo_vld = ~cmd_empty;
  assign bus.cmo_ctl = cmd_ctl_mem[cmd_rpt];
  assign bus.cmo_dat = cmd_dat_mem[cmd_rpt];
  assign bus.cmi_rdy = ~rsp_full;
  assign spi_sss     = spi_cfg[24 +: SSN];

  // Writable configuration, offsets, staging data and interrupt state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      spi_cfg     <= CFG_RST;
      adr_rof     <= ADR_ROF;
      adr_wof     <= ADR_WOF;
      dat_stg     <= '0;
      irq_ena     <= '0;
      irq_sts     <= '0;
      bus.reg_irq <= 1'b0;
    end else begin
      if (bus.reg_wen) begin
        case (bus.reg_adr)
          3'd0: spi_cfg <= (CFG_RST & ~CFG_MSK) | (bus.reg_wdt & CFG_MSK);
          3'd3: dat_stg <= bus.reg_wdt;
          3'd5: irq_ena <= bus.reg_wdt[3:0];
          3'd6: adr_rof <= bus.reg_wdt;
          3'd7: adr_wof <= bus.reg_wdt;
          default: ;
        endcase
      end
      // a same-cycle event wins over a W1C clear
      irq_sts     <= (irq_sts & ~irq_clr) | irq_set;
      bus.reg_irq <= |(irq_sts & irq_ena);
    end
  end

  // Command FIFO towards the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_wpt <= '0;
      cmd_rpt <= '0;
      cmd_cnt <= '0;
      for (int i = 0; i < CMD_DEPTH; i++) begin
        cmd_ctl_mem[i] <= '0;
        cmd_dat_mem[i] <= '0;
      end
    end else begin
      if (cmd_push) begin
        cmd_ctl_mem[cmd_wpt] <= {bus.reg_wdt[12:8], bus.reg_wdt[6:0]};
        cmd_dat_mem[cmd_wpt] <= dat_stg;
        cmd_wpt              <= cmd_wpt + 1'b1;
      end
      if (cmd_pop) cmd_rpt <= cmd_rpt + 1'b1;
      if (cmd_push && !cmd_pop)      cmd_cnt <= cmd_cnt + 1'b1;
      else if (cmd_pop && !cmd_push) cmd_cnt <= cmd_cnt - 1'b1;
    end
  end

  // Response FIFO from the sequencer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_wpt <= '0;
      rsp_rpt <= '0;
      rsp_cnt <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) rsp_mem[i] <= '0;
    end else begin
      if (rsp_push) begin
        rsp_mem[rsp_wpt] <= bus.cmi_dat;
        rsp_wpt          <= rsp_wpt + 1'b1;
      end
      if (rsp_pop) rsp_rpt <= rsp_rpt + 1'b1;
      if (rsp_push && !rsp_pop)      rsp_cnt <= rsp_cnt + 1'b1;
      else if (rsp_pop && !rsp_push) rsp_cnt <= rsp_cnt - 1'b1;
    end
  end

  // Registered read data, held until the next read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.reg_rdt <= '0;
    end else if (bus.reg_ren) begin
      case (bus.reg_adr)
        3'd0: bus.reg_rdt <= spi_cfg;
        3'd1: bus.reg_rdt <= par_val;
        3'd2: bus.reg_rdt <= sts_val;
        3'd3: bus.reg_rdt <= rsp_empty ? 32'h0 : rsp_mem[rsp_rpt];
        3'd4: bus.reg_rdt <= {28'b0, irq_sts};
        3'd5: bus.reg_rdt <= {28'b0, irq_ena};
        3'd6: bus.reg_rdt <= adr_rof;
        3'd7: bus.reg_rdt <= adr_wof;
        default: bus.reg_rdt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sockit_spi_csr.sv
// Directed bench for sockit_spi_csr: register table plus FIFO/IRQ/reset sequences.
module tb_sockit_spi_csr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] spi_cfg, adr_rof, adr_wof;
  logic [7:0]  spi_sss;
  int n_total = 0;
  int n_pass  = 0;

  sockit_spi_csr_if bus ();

  sockit_spi_csr #(
    .CFG_RST(32'h0000_0003), .CFG_MSK(32'hff00_00f0),
    .ADR_ROF(32'h0), .ADR_WOF(32'h0),
    .SSN(8), .CMD_DEPTH(4), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus.slave),
    .spi_cfg(spi_cfg), .spi_sss(spi_sss), .adr_rof(adr_rof), .adr_wof(adr_wof)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [2:0]  adr;
    logic [31:0] wdt;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.reg_wen = 1'b1; bus.reg_adr = a; bus.reg_wdt = d;
    @(negedge clk);
    bus.reg_wen = 1'b0;
  endtask

  task automatic do_read(input logic [2:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.reg_ren = 1'b1; bus.reg_adr = a;
    @(negedge clk);
    bus.reg_ren = 1'b0;
    d = bus.reg_rdt;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    bus.reg_wen = 0; bus.reg_ren = 0; bus.reg_adr = 0; bus.reg_wdt = 0;
    bus.cmo_rdy = 0; bus.cmi_vld = 0; bus.cmi_dat = 0;

    vecs[0]  = '{1'b0, 3'd6, 32'h0,          32'h0000_0000};
    vecs[1]  = '{1'b1, 3'd0, 32'hffff_ffff,  32'h0};
    vecs[2]  = '{1'b0, 3'd0, 32'h0,          32'hff00_00f3};
    vecs[3]  = '{1'b0, 3'd1, 32'h0,          32'h0202_0008};
    vecs[4]  = '{1'b1, 3'd6, 32'h1234_5678,  32'h0};
    vecs[5]  = '{1'b0, 3'd6, 32'h0,          32'h1234_5678};
    vecs[6]  = '{1'b1, 3'd7, 32'h9abc_def0,  32'h0};
    vecs[7]  = '{1'b0, 3'd7, 32'h0,          32'h9abc_def0};
    vecs[8]  = '{1'b1, 3'd5, 32'hffff_ffff,  32'h0};
    vecs[9]  = '{1'b0, 3'd5, 32'h0,          32'h0000_000f};
    vecs[10] = '{1'b1, 3'd5, 32'h0,          32'h0};
    vecs[11] = '{1'b0, 3'd2, 32'h0,          32'h0000_0003};
    vecs[12] = '{1'b0, 3'd4, 32'h0,          32'h0000_0000};

    // reset state
    do_reset();
    check("rst_cfg", spi_cfg, 32'h0000_0003);
    check("rst_rdt", bus.reg_rdt, 32'h0);
    check("rst_irq", {31'b0, bus.reg_irq}, 32'h0);
    check("rst_cmo_vld", {31'b0, bus.cmo_vld}, 32'h0);
    check("rst_cmi_rdy", {31'b0, bus.cmi_rdy}, 32'h1);

    // register map table
    for (int i = 0; i < 13; i++) begin
      if (vecs[i].wr) do_write(vecs[i].adr, vecs[i].wdt);
      else begin
        do_read(vecs[i].adr, rd);
        check($sformatf("vec%0d_adr%0d", i, vecs[i].adr), rd, vecs[i].exp);
      end
    end
    check("cfg_port", spi_cfg, 32'hff00_00f3);
    check("sss_port", {24'b0, spi_sss}, 32'h0000_00ff);
    check("wof_port", adr_wof, 32'h9abc_def0);
    do_read(3'd6, rd);
    do_write(3'd6, 32'h0);
    check("rdt_hold", bus.reg_rdt, 32'h1234_5678);

    // single command push
    do_write(3'd3, 32'hA5A5_0001);
    do_write(3'd2, 32'h0000_1F7F);
    check("cmo_vld1", {31'b0, bus.cmo_vld}, 32'h1);
    check("cmo_ctl1", {20'b0, bus.cmo_ctl}, 32'h0000_0FFF);
    check("cmo_dat1", bus.cmo_dat, 32'hA5A5_0001);
    do_read(3'd2, rd);
    check("sts_one_cmd", rd, 32'h0100_0001);

    // overflow and drain
    do_reset();
    for (int k = 0; k < 5; k++) begin
      do_write(3'd3, 32'h100 + k);
      do_write(3'd2, 32'(k));
    end
    do_read(3'd2, rd);
    check("sts_full", rd, 32'h0400_0005);
    do_read(3'd4, rd);
    check("irq_ovf", rd, 32'h0000_0004);
    bus.cmo_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("pop%0d_vld", k), {31'b0, bus.cmo_vld}, 32'h1);
      check($sformatf("pop%0d_dat", k), bus.cmo_dat, 32'h100 + k);
      check($sformatf("pop%0d_ctl", k), {20'b0, bus.cmo_ctl}, 32'(k));
      @(negedge clk);
    end
    bus.cmo_rdy = 1'b0;
    check("drained_vld", {31'b0, bus.cmo_vld}, 32'h0);
    do_read(3'd4, rd);
    check("irq_done", rd, 32'h0000_0005);
    do_read(3'd2, rd);
    check("sts_empty", rd, 32'h0000_0003);

    // response FIFO fill, drain, underflow
    do_write(3'd4, 32'hf);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("cmi_rdy%0d", k), {31'b0, bus.cmi_rdy}, 32'h1);
      bus.cmi_vld = 1'b1; bus.cmi_dat = 32'(k);
      @(negedge clk);
    end
    bus.cmi_vld = 1'b0;
    check("cmi_rdy_full", {31'b0, bus.cmi_rdy}, 32'h0);
    do_read(3'd2, rd);
    check("sts_rsp4", rd, 32'h0004_0002);
    for (int k = 1; k <= 4; k++) begin
      do_read(3'd3, rd);
      check($sformatf("rsp%0d", k), rd, 32'(k));
    end
    do_read(3'd3, rd);
    check("rsp_udf_val", rd, 32'h0);
    do_read(3'd4, rd);
    check("irq_udf", rd, 32'h0000_000a);

    // interrupt latency and W1C vs set priority
    do_write(3'd4, 32'hf);
    do_write(3'd5, 32'h2);
    check("irq_idle", {31'b0, bus.reg_irq}, 32'h0);
    @(negedge clk);
    bus.cmi_vld = 1'b1; bus.cmi_dat = 32'h55;
    @(negedge clk);
    bus.cmi_vld = 1'b0;
    check("irq_lat0", {31'b0, bus.reg_irq}, 32'h0);
    @(negedge clk);
    check("irq_rise", {31'b0, bus.reg_irq}, 32'h1);
    bus.reg_wen = 1'b1; bus.reg_adr = 3'd4; bus.reg_wdt = 32'h2;
    bus.cmi_vld = 1'b1; bus.cmi_dat = 32'h66;
    @(negedge clk);
    bus.reg_wen = 1'b0; bus.cmi_vld = 1'b0;
    do_read(3'd4, rd);
    check("set_wins", rd, 32'h0000_0002);
    do_read(3'd2, rd);
    check("sts_rsp2", rd, 32'h0002_0002);
    do_write(3'd4, 32'h2);
    check("irq_hold", {31'b0, bus.reg_irq}, 32'h1);
    @(negedge clk);
    check("irq_fall", {31'b0, bus.reg_irq}, 32'h0);

    // asynchronous reset with queued commands
    for (int k = 0; k < 3; k++) do_write(3'd2, 32'(k));
    check("pre_rst_vld", {31'b0, bus.cmo_vld}, 32'h1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_vld", {31'b0, bus.cmo_vld}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    do_read(3'd2, rd);
    check("post_rst_sts", rd, 32'h0000_0003);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
